// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, ALU write, load issue/write-back,
// read-only constants and status outputs. The core drives via master, the register file is the slave.
interface regfile_sb_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int NUM_RO   = 3,
   parameter int ADDR_W   = $clog2(NUM_REGS)
);
   logic [ADDR_W-1:0]        rd_addr1;
   logic [ADDR_W-1:0]        rd_addr2;
   logic [DATA_W-1:0]        rd_data1;
   logic [DATA_W-1:0]        rd_data2;
   logic                     rd_busy1;
   logic                     rd_busy2;
   logic                     alu_we;
   logic [ADDR_W-1:0]        alu_waddr;
   logic [DATA_W-1:0]        alu_wdata;
   logic                     ld_issue_valid;
   logic [ADDR_W-1:0]        ld_issue_addr;
   logic                     ld_issue_ready;
   logic                     ld_wb_valid;
   logic [ADDR_W-1:0]        ld_wb_addr;
   logic [DATA_W-1:0]        ld_wb_data;
   logic [NUM_RO*DATA_W-1:0] ro_values;
   logic [NUM_REGS-1:0]      busy_vec;
   logic [ADDR_W:0]          pending_cnt;
   logic [2:0]               err;

   modport master (
      output rd_addr1, rd_addr2, alu_we, alu_waddr, alu_wdata,
             ld_issue_valid, ld_issue_addr, ld_wb_valid, ld_wb_addr, ld_wb_data, ro_values,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, ld_issue_ready, busy_vec, pending_cnt, err
   );

   modport slave (
      input  rd_addr1, rd_addr2, alu_we, alu_waddr, alu_wdata,
             ld_issue_valid, ld_issue_addr, ld_wb_valid, ld_wb_addr, ld_wb_data, ro_values,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, ld_issue_ready, busy_vec, pending_cnt, err
   );
endinterface

// File: rtl/regfile_sb.sv
// Per-thread register file with load scoreboard, second write port for load write-back and RO constants.
// Optional same-cycle read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 16,
   parameter int NUM_RO   = 3,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   regfile_sb_if.slave   rf
);
   localparam int NUM_GP = NUM_REGS - NUM_RO;
   localparam logic [ADDR_W-1:0] GP_LIM = ADDR_W'(NUM_GP);

   logic [DATA_W-1:0]   regs_q [NUM_GP];
   logic [DATA_W-1:0]   regs_d [NUM_GP];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [ADDR_W:0]     pend_q;
   logic [ADDR_W:0]     pend_d;
   logic [2:0]          err_q;
   logic [2:0]          err_d;

   logic                alu_gp_s;
   logic                alu_ok_s;
   logic                wb_hit_s;
   logic                iss_ready_s;
   logic                iss_acc_s;
   logic [ADDR_W-1:0]   ra_s [2];
   logic [2*DATA_W-1:0] rdat_all_s;
   logic [1:0]          rbusy_all_s;

   // An ALU write to a busy register is dropped even if that register is written back this cycle.
   assign alu_gp_s    = (rf.alu_waddr < GP_LIM);
   assign alu_ok_s    = rf.alu_we & alu_gp_s & ~busy_q[rf.alu_waddr];
   assign wb_hit_s    = rf.ld_wb_valid & busy_q[rf.ld_wb_addr];
   assign iss_ready_s = (rf.ld_issue_addr < GP_LIM) & ~busy_q[rf.ld_issue_addr];
   assign iss_acc_s   = rf.ld_issue_valid & iss_ready_s;

   // Next-state for storage, scoreboard, outstanding count and sticky errors.
   always_comb begin
      for (int i = 0; i < NUM_GP; i++) begin
         if (wb_hit_s && (rf.ld_wb_addr == ADDR_W'(i))) begin
            regs_d[i] = rf.ld_wb_data;
         end else if (alu_ok_s && (rf.alu_waddr == ADDR_W'(i))) begin
            regs_d[i] = rf.alu_wdata;
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i >= NUM_GP) begin
            busy_d[i] = 1'b0;
         end else if (iss_acc_s && (rf.ld_issue_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if (wb_hit_s && (rf.ld_wb_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
      pend_d   = pend_q + (ADDR_W+1)'(iss_acc_s) - (ADDR_W+1)'(wb_hit_s);
      err_d[0] = err_q[0] | (rf.alu_we & ~alu_gp_s);
      err_d[1] = err_q[1] | (rf.alu_we & alu_gp_s & busy_q[rf.alu_waddr]);
      err_d[2] = err_q[2] | (rf.ld_wb_valid & ~busy_q[rf.ld_wb_addr]);
   end

   // State registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_GP; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         busy_q <= {NUM_REGS{1'b0}};
         pend_q <= {(ADDR_W+1){1'b0}};
         err_q  <= 3'b000;
      end else begin
         for (int i = 0; i < NUM_GP; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end

   assign ra_s[0] = rf.rd_addr1;
   assign ra_s[1] = rf.rd_addr2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      logic [ADDR_W-1:0] ro_off_s;
      logic [DATA_W-1:0] base_s;
      logic [DATA_W-1:0] rd_s;
      logic              bz_s;
      logic              wb_fwd_s;
      logic              alu_fwd_s;

      // Read mux: RO constants are live, GP reads come from storage (optionally forwarded).
      always_comb begin
         ro_off_s  = ra_s[p] - GP_LIM;
         wb_fwd_s  = wb_hit_s & (rf.ld_wb_addr == ra_s[p]);
         alu_fwd_s = alu_ok_s & (rf.alu_waddr == ra_s[p]);
         if (ra_s[p] >= GP_LIM) begin
            base_s = rf.ro_values[int'(ro_off_s)*DATA_W +: DATA_W];
         end else begin
            base_s = regs_q[ra_s[p]];
         end
`ifdef REGFILE_BYPASS_EN
         rd_s = wb_fwd_s ? rf.ld_wb_data : (alu_fwd_s ? rf.alu_wdata : base_s);
         bz_s = busy_q[ra_s[p]] & ~wb_fwd_s;
`else
         rd_s = base_s;
         bz_s = busy_q[ra_s[p]] & ~(wb_fwd_s & alu_fwd_s);
`endif
      end

      assign rdat_all_s[p*DATA_W +: DATA_W] = rd_s;
      assign rbusy_all_s[p]                 = bz_s;
   end

   assign rf.rd_data1       = rdat_all_s[DATA_W-1:0];
   assign rf.rd_data2       = rdat_all_s[2*DATA_W-1:DATA_W];
   assign rf.rd_busy1       = rbusy_all_s[0];
   assign rf.rd_busy2       = rbusy_all_s[1];
   assign rf.ld_issue_ready = iss_ready_s;
   assign rf.busy_vec       = busy_q;
   assign rf.pending_cnt    = pend_q;
   assign rf.err            = err_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic against an array-based model.
module tb_regfile_sb;
   localparam int DW = 8;
   localparam int NR = 16;
   localparam int NRO = 3;
   localparam int NGP = NR - NRO;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   logic [7:0]  mregs [NR];
   bit          mbusy [NR];
   logic [2:0]  merr;
   logic [23:0] rov;

   regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RO(NRO)) rf ();

   regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RO(NRO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rf      (rf)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   function automatic int popcnt();
      int c = 0;
      for (int i = 0; i < NR; i++) c += int'(mbusy[i]);
      return c;
   endfunction

   function automatic logic [15:0] busy_packed();
      logic [15:0] v = 16'h0000;
      for (int i = 0; i < NR; i++) v[i] = mbusy[i];
      return v;
   endfunction

   function automatic bit wb_fwd(int a);
      return rf.ld_wb_valid && (int'(rf.ld_wb_addr) == a) && (a < NGP) && mbusy[a];
   endfunction

   function automatic bit alu_fwd(int a);
      return rf.alu_we && (int'(rf.alu_waddr) == a) && (a < NGP) && !mbusy[a];
   endfunction

   function automatic logic [7:0] exp_data(int a);
      if (a >= NGP) return rov[(a-NGP)*8 +: 8];
`ifdef REGFILE_BYPASS_EN
      if (wb_fwd(a)) return rf.ld_wb_data;
      if (alu_fwd(a)) return rf.alu_wdata;
`endif
      return mregs[a];
   endfunction

   function automatic bit exp_busy(int a);
      if (a >= NGP) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (wb_fwd(a)) return 1'b0;
`endif
      return mbusy[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         mregs[i] = 8'h00;
         mbusy[i] = 1'b0;
      end
      merr = 3'b000;
   endtask

   task automatic idle();
      rf.alu_we         = 1'b0;
      rf.alu_waddr      = 4'h0;
      rf.alu_wdata      = 8'h00;
      rf.ld_issue_valid = 1'b0;
      rf.ld_issue_addr  = 4'h0;
      rf.ld_wb_valid    = 1'b0;
      rf.ld_wb_addr     = 4'h0;
      rf.ld_wb_data     = 8'h00;
   endtask

   task automatic check_state(string tag);
      n_checks++;
      if (rf.busy_vec !== busy_packed()) begin
         n_errors++;
         $display("FAIL %s busy_vec: got %h expected %h", tag, rf.busy_vec, busy_packed());
      end
      n_checks++;
      if (rf.pending_cnt !== 5'(popcnt())) begin
         n_errors++;
         $display("FAIL %s pending_cnt: got %0d expected %0d", tag, rf.pending_cnt, popcnt());
      end
      n_checks++;
      if (rf.err !== merr) begin
         n_errors++;
         $display("FAIL %s err: got %b expected %b", tag, rf.err, merr);
      end
   endtask

   // Sweeps both read ports over every address; must be called well inside a clock phase.
   task automatic check_reads(string tag);
      for (int i = 0; i < NR; i++) begin
         rf.rd_addr1 = 4'(i);
         rf.rd_addr2 = 4'(NR-1-i);
         #1;
         n_checks++;
         if (rf.rd_data1 !== exp_data(i) || rf.rd_busy1 !== exp_busy(i)) begin
            n_errors++;
            $display("FAIL %s rd1[%0d]: got %h/%b expected %h/%b", tag, i, rf.rd_data1, rf.rd_busy1, exp_data(i), exp_busy(i));
         end
         n_checks++;
         if (rf.rd_data2 !== exp_data(NR-1-i) || rf.rd_busy2 !== exp_busy(NR-1-i)) begin
            n_errors++;
            $display("FAIL %s rd2[%0d]: got %h/%b expected %h/%b", tag, NR-1-i, rf.rd_data2, rf.rd_busy2, exp_data(NR-1-i), exp_busy(NR-1-i));
         end
      end
   endtask

   // Checks issue readiness, advances one clock and applies the architectural rules to the model.
   task automatic tick(string tag);
      logic [7:0] nregs [NR];
      bit         nbusy [NR];
      logic [2:0] nerr;
      int wa, wb, ia;
      bit rdy, alu_ok, wb_ok;
      wa = int'(rf.alu_waddr);
      wb = int'(rf.ld_wb_addr);
      ia = int'(rf.ld_issue_addr);
      rdy = (ia < NGP) && !mbusy[ia];
      #1;
      n_checks++;
      if (rf.ld_issue_ready !== rdy) begin
         n_errors++;
         $display("FAIL %s ld_issue_ready[%0d]: got %b expected %b", tag, ia, rf.ld_issue_ready, rdy);
      end
      alu_ok = rf.alu_we && (wa < NGP) && !mbusy[wa];
      wb_ok  = rf.ld_wb_valid && mbusy[wb];
      nregs = mregs;
      nbusy = mbusy;
      nerr  = merr;
      if (rf.alu_we && wa >= NGP) nerr[0] = 1'b1;
      if (rf.alu_we && wa < NGP && mbusy[wa]) nerr[1] = 1'b1;
      if (rf.ld_wb_valid && !wb_ok) nerr[2] = 1'b1;
      if (alu_ok) nregs[wa] = rf.alu_wdata;
      if (wb_ok) begin
         nregs[wb] = rf.ld_wb_data;
         nbusy[wb] = 1'b0;
      end
      if (rf.ld_issue_valid && rdy) nbusy[ia] = 1'b1;
      @(posedge clk);
      #1;
      mregs = nregs;
      mbusy = nbusy;
      merr  = nerr;
      check_state(tag);
   endtask

   task automatic apply_reset(string tag);
      reset_n = 1'b0;
      model_reset();
      #5;
      check_state(tag);
      rf.ld_issue_addr = 4'h0;
      #1;
      n_checks++;
      if (rf.ld_issue_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL %s ready_after_reset: got %b expected 1", tag, rf.ld_issue_ready);
      end
      check_reads(tag);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      rov = 24'h000000;
      rf.ro_values = rov;
      apply_reset("reset");
   endtask

   task automatic test_ro();
      rov = {8'h05, 8'h04, 8'h02};
      rf.ro_values = rov;
      rf.rd_addr1 = 4'd13;
      rf.rd_addr2 = 4'd15;
      #1;
      n_checks++;
      if (rf.rd_data1 !== 8'h02 || rf.rd_data2 !== 8'h05) begin
         n_errors++;
         $display("FAIL ro_read: got %h/%h expected 02/05", rf.rd_data1, rf.rd_data2);
      end
      rf.alu_we = 1'b1;
      rf.alu_waddr = 4'd14;
      rf.alu_wdata = 8'hAA;
      tick("ro_write");
      idle();
      rf.rd_addr1 = 4'd14;
      #1;
      n_checks++;
      if (rf.err[0] !== 1'b1 || rf.rd_data1 !== 8'h04) begin
         n_errors++;
         $display("FAIL ro_write_drop: got err0=%b data=%h expected 1/04", rf.err[0], rf.rd_data1);
      end
      check_reads("ro");
   endtask

   task automatic test_alu_write();
      rf.alu_we = 1'b1;
      rf.alu_waddr = 4'd3;
      rf.alu_wdata = 8'h3C;
`ifdef REGFILE_BYPASS_EN
      rf.rd_addr1 = 4'd3;
      #1;
      n_checks++;
      if (rf.rd_data1 !== 8'h3C) begin
         n_errors++;
         $display("FAIL alu_bypass: got %h expected 3C", rf.rd_data1);
      end
`endif
      tick("alu_write");
      idle();
      rf.rd_addr1 = 4'd3;
      #1;
      n_checks++;
      if (rf.rd_data1 !== 8'h3C) begin
         n_errors++;
         $display("FAIL alu_read: got %h expected 3C", rf.rd_data1);
      end
   endtask

   task automatic test_load();
      rf.ld_issue_valid = 1'b1;
      rf.ld_issue_addr = 4'd5;
      tick("issue_r5");
      n_checks++;
      if (rf.busy_vec[5] !== 1'b1 || rf.pending_cnt !== 5'd1) begin
         n_errors++;
         $display("FAIL issue_r5: got busy=%b cnt=%0d expected 1/1", rf.busy_vec[5], rf.pending_cnt);
      end
      #1;
      n_checks++;
      if (rf.ld_issue_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL reissue_r5: got ready=%b expected 0", rf.ld_issue_ready);
      end
      tick("reissue_r5");
      idle();
      rf.ld_wb_valid = 1'b1;
      rf.ld_wb_addr = 4'd5;
      rf.ld_wb_data = 8'h77;
      check_reads("wb_r5_pre");
      tick("wb_r5");
      idle();
      rf.rd_addr1 = 4'd5;
      #1;
      n_checks++;
      if (rf.rd_data1 !== 8'h77 || rf.rd_busy1 !== 1'b0 || rf.pending_cnt !== 5'd0) begin
         n_errors++;
         $display("FAIL wb_r5: got %h/%b/%0d expected 77/0/0", rf.rd_data1, rf.rd_busy1, rf.pending_cnt);
      end
   endtask

   task automatic test_simultaneous();
      rf.ld_issue_valid = 1'b1;
      rf.ld_issue_addr = 4'd2;
      tick("issue_r2");
      idle();
      rf.alu_we = 1'b1;
      rf.alu_waddr = 4'd2;
      rf.alu_wdata = 8'h11;
      rf.ld_wb_valid = 1'b1;
      rf.ld_wb_addr = 4'd2;
      rf.ld_wb_data = 8'h22;
      check_reads("alu_wb_pre");
      tick("alu_wb_r2");
      idle();
      rf.rd_addr1 = 4'd2;
      #1;
      n_checks++;
      if (rf.rd_data1 !== 8'h22 || rf.err[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL alu_wb_r2: got %h err1=%b expected 22/1", rf.rd_data1, rf.err[1]);
      end
      rf.ld_issue_valid = 1'b1;
      rf.ld_issue_addr = 4'd6;
      tick("issue_r6");
      rf.ld_issue_addr = 4'd4;
      rf.ld_wb_valid = 1'b1;
      rf.ld_wb_addr = 4'd6;
      rf.ld_wb_data = 8'h66;
      tick("issue_r4_wb_r6");
      idle();
      n_checks++;
      if (rf.pending_cnt !== 5'd1 || rf.busy_vec[4] !== 1'b1 || rf.busy_vec[6] !== 1'b0) begin
         n_errors++;
         $display("FAIL issue_wb_mix: got cnt=%0d b4=%b b6=%b expected 1/1/0", rf.pending_cnt, rf.busy_vec[4], rf.busy_vec[6]);
      end
      check_reads("simul");
   endtask

   task automatic test_random();
      int q[$];
      for (int cyc = 0; cyc < 400; cyc++) begin
         q.delete();
         for (int i = 0; i < NGP; i++) if (mbusy[i]) q.push_back(i);
         rf.alu_we = ($urandom_range(0, 2) == 0);
         rf.alu_waddr = 4'($urandom_range(0, 15));
         rf.alu_wdata = 8'($urandom);
         rf.ld_issue_valid = ($urandom_range(0, 1) == 0);
         rf.ld_issue_addr = 4'($urandom_range(0, 15));
         rf.ld_wb_valid = ($urandom_range(0, 2) != 0);
         if (q.size() > 0 && $urandom_range(0, 4) != 0) rf.ld_wb_addr = 4'(q[$urandom_range(0, q.size()-1)]);
         else rf.ld_wb_addr = 4'($urandom_range(0, 15));
         rf.ld_wb_data = 8'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            rov = 24'($urandom);
            rf.ro_values = rov;
         end
         if (cyc % 4 == 0) check_reads("random");
         tick("random");
      end
      idle();
   endtask

   task automatic test_full_reset();
      for (int i = 0; i < NGP; i++) begin
         rf.ld_issue_valid = 1'b1;
         rf.ld_issue_addr = 4'(i);
         tick("fill");
      end
      idle();
      n_checks++;
      if (rf.pending_cnt !== 5'd13) begin
         n_errors++;
         $display("FAIL fill_cnt: got %0d expected 13", rf.pending_cnt);
      end
      for (int i = 0; i < NGP; i++) begin
         rf.ld_issue_addr = 4'(i);
         #1;
         n_checks++;
         if (rf.ld_issue_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready[%0d]: got %b expected 0", i, rf.ld_issue_ready);
         end
      end
      apply_reset("mid_reset");
      rf.ld_wb_valid = 1'b1;
      rf.ld_wb_addr = 4'd7;
      rf.ld_wb_data = 8'hEE;
      tick("spurious_wb");
      idle();
      rf.rd_addr1 = 4'd7;
      #1;
      n_checks++;
      if (rf.err !== 3'b100 || rf.rd_data1 !== 8'h00) begin
         n_errors++;
         $display("FAIL spurious_wb: got err=%b r7=%h expected 100/00", rf.err, rf.rd_data1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n = 1'b0;
      rf.rd_addr1 = 4'h0;
      rf.rd_addr2 = 4'h0;
      test_reset();
      test_ro();
      test_alu_write();
      test_load();
      test_simultaneous();
      test_random();
      test_full_reset();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
